// File: rtl/dcache_responder_pkg.sv
// Shared types and constants for the data-cache responder.
// Holds FSM encoding, counter width and the optional stall LFSR constants.
package dcache_responder_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    WBUSY = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port word array with byte write enables; the combinational read
// returns the addressed word already merged with any same-cycle write.
module mem_array_1rw
  import dcache_responder_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_we,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] w_old;

  assign w_old = r_mem[i_addr];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign o_rdata[8*gi +: 8] = i_we[gi] ? i_wdata[8*gi +: 8] : w_old[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dcache_responder.sv
// Blocking single-outstanding data-memory responder with configurable latency.
// Optional macro MEM_RAND_STALL_EN adds LFSR-driven random read and accept stalls.
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1,
  parameter int WRITE_BUSY  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] dout
);

  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef MEM_RAND_STALL_EN
  // One extra bit so LATENCY plus up to three stall cycles still fits
  localparam int CW = CNT_W + 1;
`else
  localparam int CW = CNT_W;
`endif

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_ready;
  logic          r_valid;
  logic [31:0]   r_dout;

  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_accept;
  logic [3:0]    w_mem_we;
  logic [31:0]   w_rd_word;
  logic [1:0]    w_extra;
  logic [CW-1:0] w_lat;
  logic          w_ready_next;
  logic          w_unused;

  assign w_unused = ^{addr[1:0], addr[31:AW+2]};
  assign w_accept = (re || (we != 4'b0)) && r_ready;
  assign w_mem_we = w_accept ? we : 4'b0;

  mem_array_1rw #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_mem (
    .clk     (clk),
    .i_addr  (addr[AW+1:2]),
    .i_we    (w_mem_we),
    .i_wdata (din),
    .o_rdata (w_rd_word)
  );

`ifdef MEM_RAND_STALL_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  assign w_lfsr_next = lfsr_step(r_lfsr);
  assign w_extra     = r_lfsr[1:0];
  assign w_ready_next = (w_state_next == RESP) ||
                        ((w_state_next == IDLE) && (w_lfsr_next[3:2] != 2'b00));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= w_lfsr_next;
  end
`else
  assign w_extra      = 2'b00;
  assign w_ready_next = (w_state_next == IDLE) || (w_state_next == RESP);
`endif

  assign w_lat = CW'(LATENCY) + CW'(w_extra);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        w_state_next = IDLE;
        if (w_accept) begin
          if (re) begin
            if (w_lat == CW'(1)) begin
              w_state_next = RESP;
            end else begin
              w_state_next = WAIT;
              w_cnt_next   = w_lat - CW'(1);
            end
          end else if (WRITE_BUSY != 0) begin
            w_state_next = WBUSY;
            w_cnt_next   = CW'(WRITE_BUSY);
          end
        end
      end
      WAIT: begin
        if (r_cnt <= CW'(1)) w_state_next = RESP;
        else                 w_cnt_next   = r_cnt - CW'(1);
      end
      WBUSY: begin
        if (r_cnt <= CW'(1)) w_state_next = IDLE;
        else                 w_cnt_next   = r_cnt - CW'(1);
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= (w_state_next == WAIT || w_state_next == WBUSY) ? w_cnt_next : '0;
      r_ready <= w_ready_next;
      r_valid <= (w_state_next == RESP);
      if (w_accept && re) r_rdata <= w_rd_word;
      // Data is captured at acceptance; WAIT only delays its release
      if (w_state_next == RESP) r_dout <= (r_state == WAIT) ? r_rdata : w_rd_word;
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_valid;
  assign dout       = r_dout;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: three instances (LATENCY 1, 4 and 8)
// share address/data and reset; each has its own request strobes.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic        re_v   [3];
  logic [3:0]  we_v   [3];
  logic        rdy_v  [3];
  logic        vld_v  [3];
  logic [31:0] dout_v [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dcache_responder #(.DEPTH_WORDS(4096), .LATENCY(1), .WRITE_BUSY(0)) u_dut1 (
    .clk(clk), .reset(rst_n), .addr(addr), .re(re_v[0]), .we(we_v[0]), .din(din),
    .req_ready(rdy_v[0]), .resp_valid(vld_v[0]), .dout(dout_v[0]));
  dcache_responder #(.DEPTH_WORDS(4096), .LATENCY(4), .WRITE_BUSY(2)) u_dut4 (
    .clk(clk), .reset(rst_n), .addr(addr), .re(re_v[1]), .we(we_v[1]), .din(din),
    .req_ready(rdy_v[1]), .resp_valid(vld_v[1]), .dout(dout_v[1]));
  dcache_responder #(.DEPTH_WORDS(4096), .LATENCY(8), .WRITE_BUSY(0)) u_dut8 (
    .clk(clk), .reset(rst_n), .addr(addr), .re(re_v[2]), .we(we_v[2]), .din(din),
    .req_ready(rdy_v[2]), .resp_valid(vld_v[2]), .dout(dout_v[2]));

  // Issue one request to instance k starting at a negedge; returns at a negedge.
  // lat is cycles from acceptance to resp_valid, 0 for writes, -1 on timeout.
  task automatic op(input int k, input logic [31:0] a, input logic [3:0] w,
                    input logic [31:0] d, input logic r,
                    output logic [31:0] q, output int lat);
    int g = 0;
    q = '0;
    addr = a; din = d; we_v[k] = w; re_v[k] = r;
    while (!rdy_v[k] && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) begin
      lat = -1; we_v[k] = 4'b0; re_v[k] = 1'b0;
      return;
    end
    @(posedge clk); @(negedge clk);
    we_v[k] = 4'b0; re_v[k] = 1'b0;
    lat = 0;
    if (r) begin
      lat = 1;
      while (!vld_v[k] && lat < 40) begin @(negedge clk); lat++; end
      q = dout_v[k];
      if (lat >= 40) lat = -1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rdy_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, rdy_v[k]); end
      n_checks++;
      if (vld_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, vld_v[k]); end
      n_checks++;
      if (dout_v[k] !== 32'h0) begin n_fail++; $display("FAIL reset_dout[%0d]: got %h expected 0", k, dout_v[k]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
`ifndef MEM_RAND_STALL_EN
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rdy_v[k] !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready[%0d]: got %b expected 1", k, rdy_v[k]); end
    end
`endif
    $display("reset: released");
  endtask

  task automatic test_write_read;
    logic [31:0] q; int lat;
    op(0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, q, lat);
    op(0, 32'h10, 4'h0, 32'h0, 1'b1, q, lat);
    $display("write_read: addr=0x10 dout=%h lat=%0d", q, lat);
    n_checks++;
    if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read_data: got %h expected deadbeef", q); end
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL write_read_lat: got %0d expected 1", lat); end
  endtask

  task automatic test_byte_mask;
    logic [31:0] q; int lat;
    op(0, 32'h10, 4'b0101, 32'h11223344, 1'b0, q, lat);
    op(0, 32'h10, 4'h0, 32'h0, 1'b1, q, lat);
    $display("byte_mask: dout=%h", q);
    n_checks++;
    if (q !== 32'hDE22BE44) begin n_fail++; $display("FAIL byte_mask: got %h expected de22be44", q); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q; int lat;
    op(0, 32'h14, 4'hF, 32'h0BADF00D, 1'b0, q, lat);
    addr = 32'h10; re_v[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (vld_v[0] !== 1'b1 || dout_v[0] !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL b2b_first: got valid=%b dout=%h expected 1 de22be44", vld_v[0], dout_v[0]);
    end
    n_checks++;
    if (rdy_v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", rdy_v[0]); end
    addr = 32'h14;
    @(posedge clk); @(negedge clk);
    re_v[0] = 1'b0;
    n_checks++;
    if (vld_v[0] !== 1'b1 || dout_v[0] !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL b2b_second: got valid=%b dout=%h expected 1 0badf00d", vld_v[0], dout_v[0]);
    end
    @(negedge clk);
    n_checks++;
    if (vld_v[0] !== 1'b0 || dout_v[0] !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL b2b_hold: got valid=%b dout=%h expected 0 0badf00d", vld_v[0], dout_v[0]);
    end
    $display("back_to_back: two reads at full rate");
  endtask

  task automatic test_wrap;
    logic [31:0] q; int lat;
    op(0, 32'h4010, 4'hF, 32'hCAFEF00D, 1'b0, q, lat);
    op(0, 32'h0010, 4'h0, 32'h0, 1'b1, q, lat);
    $display("wrap: addr=0x0010 dout=%h", q);
    n_checks++;
    if (q !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap: got %h expected cafef00d", q); end
    op(0, 32'h0013, 4'h0, 32'h0, 1'b1, q, lat);
    $display("wrap: addr=0x0013 dout=%h", q);
    n_checks++;
    if (q !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap_lowbits: got %h expected cafef00d", q); end
  endtask

  task automatic test_rw_merge;
    logic [31:0] q; int lat;
    op(0, 32'h18, 4'hF, 32'hAABBCCDD, 1'b0, q, lat);
    op(0, 32'h18, 4'b0011, 32'h00001122, 1'b1, q, lat);
    $display("rw_merge: dout=%h lat=%0d", q, lat);
    n_checks++;
    if (q !== 32'hAABB1122) begin n_fail++; $display("FAIL rw_merge: got %h expected aabb1122", q); end
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL rw_merge_lat: got %0d expected 1", lat); end
  endtask

`ifndef MEM_RAND_STALL_EN
  task automatic test_latency;
    logic [31:0] q; int lat;
    op(1, 32'h20, 4'hF, 32'h12345678, 1'b0, q, lat);
    // WRITE_BUSY=2: ready stays low two cycles after the write
    n_checks++;
    if (rdy_v[1] !== 1'b0) begin n_fail++; $display("FAIL wbusy_1: got %b expected 0", rdy_v[1]); end
    @(negedge clk);
    n_checks++;
    if (rdy_v[1] !== 1'b0) begin n_fail++; $display("FAIL wbusy_2: got %b expected 0", rdy_v[1]); end
    @(negedge clk);
    n_checks++;
    if (rdy_v[1] !== 1'b1) begin n_fail++; $display("FAIL wbusy_end: got %b expected 1", rdy_v[1]); end
    addr = 32'h20; re_v[1] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (r == 1 && c == 1) re_v[1] = 1'b0;
        n_checks++;
        if (c < 4 && (rdy_v[1] !== 1'b0 || vld_v[1] !== 1'b0)) begin
          n_fail++; $display("FAIL latency_wait r%0d c%0d: got ready=%b valid=%b expected 0 0", r, c, rdy_v[1], vld_v[1]);
        end
        if (c == 4 && (rdy_v[1] !== 1'b1 || vld_v[1] !== 1'b1 || dout_v[1] !== 32'h12345678)) begin
          n_fail++; $display("FAIL latency_resp r%0d: got ready=%b valid=%b dout=%h expected 1 1 12345678", r, rdy_v[1], vld_v[1], dout_v[1]);
        end
      end
    end
    @(negedge clk);
    $display("latency: two LATENCY=4 reads with re held");
  endtask
`endif

  task automatic test_reset_mid_read;
    logic [31:0] q; int lat; int nvalid;
    op(2, 32'h30, 4'hF, 32'h55667788, 1'b0, q, lat);
    addr = 32'h30; re_v[2] = 1'b1;
    while (!rdy_v[2]) @(negedge clk);
    @(posedge clk); @(negedge clk);
    re_v[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rdy_v[2] !== 1'b0 || vld_v[2] !== 1'b0 || dout_v[2] !== 32'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got ready=%b valid=%b dout=%h expected 0 0 0", rdy_v[2], vld_v[2], dout_v[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    repeat (12) begin @(negedge clk); if (vld_v[2] === 1'b1) nvalid++; end
    n_checks++;
    if (nvalid != 0) begin n_fail++; $display("FAIL midreset_no_resp: got %0d pulses expected 0", nvalid); end
    n_checks++;
    if (dout_v[2] !== 32'h0) begin n_fail++; $display("FAIL midreset_dout: got %h expected 0", dout_v[2]); end
    op(2, 32'h30, 4'h0, 32'h0, 1'b1, q, lat);
    $display("reset_mid_read: reread dout=%h lat=%0d", q, lat);
    n_checks++;
    if (q !== 32'h55667788) begin n_fail++; $display("FAIL midreset_mem: got %h expected 55667788", q); end
`ifndef MEM_RAND_STALL_EN
    n_checks++;
    if (lat != 8) begin n_fail++; $display("FAIL midreset_lat: got %0d expected 8", lat); end
`endif
    op(0, 32'h14, 4'h0, 32'h0, 1'b1, q, lat);
    n_checks++;
    if (q !== 32'h0BADF00D) begin n_fail++; $display("FAIL midreset_mem1: got %h expected 0badf00d", q); end
  endtask

  task automatic test_random;
    logic [31:0] model [64];
    logic [31:0] q, d, exp; logic [3:0] w; int lat, kind, idx, bad;
    for (int i = 0; i < 64; i++) begin
      model[i] = $urandom;
      op(1, 32'h400 + 32'(i * 4), 4'hF, model[i], 1'b0, q, lat);
    end
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 2);
      idx  = $urandom_range(0, 63);
      d    = $urandom;
      w    = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      for (int b = 0; b < 4; b++) if (w[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      exp = model[idx];
      op(1, 32'h400 + 32'(idx * 4) + 32'($urandom_range(0, 3)), w, d, kind != 1, q, lat);
      if (kind != 1) begin
        n_checks++;
        if (q !== exp) begin n_fail++; bad++; $display("FAIL random_data #%0d: got %h expected %h", n, q, exp); end
        n_checks++;
`ifdef MEM_RAND_STALL_EN
        if (lat < 4 || lat > 7) begin n_fail++; bad++; $display("FAIL random_lat #%0d: got %0d expected 4..7", n, lat); end
`else
        if (lat != 4) begin n_fail++; bad++; $display("FAIL random_lat #%0d: got %0d expected 4", n, lat); end
`endif
      end else begin
        n_checks++;
        if (lat != 0) begin n_fail++; bad++; $display("FAIL random_write #%0d: timeout", n); end
      end
    end
    $display("random: 200 ops, %0d bad", bad);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin re_v[k] = 1'b0; we_v[k] = 4'b0; end
    @(negedge clk);
    test_reset;
    test_write_read;
    test_byte_mask;
    test_back_to_back;
    test_wrap;
    test_rw_merge;
`ifndef MEM_RAND_STALL_EN
    test_latency;
`endif
    test_reset_mid_read;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
